// File: rtl/parameters_pkg.sv
// Shared types and constants for the UART receiver.
// Frame FSM encoding, field widths, legal prescales and the voter.
package parameters_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int PRESCALE_W = 6;

  localparam logic [PRESCALE_W-1:0] PRESCALE_8  = 6'd8;
  localparam logic [PRESCALE_W-1:0] PRESCALE_16 = 6'd16;
  localparam logic [PRESCALE_W-1:0] PRESCALE_32 = 6'd32;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    OUT
  } rx_state_t;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial line, frame configuration and word/strobe bundle of the receiver.
// master drives the line and config; slave is the receiver.
interface uart_rx_if #(
  parameter int DATA_WIDTH = parameters_pkg::DATA_WIDTH,
  parameter int PRESCALE_W = parameters_pkg::PRESCALE_W
);

  logic                  RX_IN;
  logic [PRESCALE_W-1:0] prescale;
  logic                  parity_enable;
  logic                  parity_type;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  parity_error;
  logic                  stop_error;

  modport master (
    output RX_IN,
    output prescale,
    output parity_enable,
    output parity_type,
    input  P_DATA,
    input  data_valid,
    input  parity_error,
    input  stop_error
  );

  modport slave (
    input  RX_IN,
    input  prescale,
    input  parity_enable,
    input  parity_type,
    output P_DATA,
    output data_valid,
    output parity_error,
    output stop_error
  );

endinterface

// File: rtl/uart_rx_data_sampling.sv
// Mid-bit sampler: three samples around P/2, majority-voted.
// sample_done marks the decision cycle at edge P/2+2.
module data_sampling
  import parameters_pkg::*;
#(
  parameter int PRESCALE_W = parameters_pkg::PRESCALE_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  sampled_bit,
  output logic                  sample_done
);

  logic [PRESCALE_W-1:0] half;
  logic [2:0]            smp;

  assign half = prescale >> 1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      smp <= '0;
    end else begin
      if (edge_cnt == half - PRESCALE_W'(1))
        smp[0] <= rx_in;
      if (edge_cnt == half)
        smp[1] <= rx_in;
      if (edge_cnt == half + PRESCALE_W'(1))
        smp[2] <= rx_in;
    end
  end

  assign sampled_bit = maj3(smp);
  assign sample_done = (edge_cnt == half + PRESCALE_W'(2));

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled frame FSM, LSB-first shifter, parity/stop check.
// Config is captured at the start edge and held for the whole frame.
module uart_rx
  import parameters_pkg::*;
#(
  parameter int DATA_WIDTH = parameters_pkg::DATA_WIDTH,
  parameter int PRESCALE_W = parameters_pkg::PRESCALE_W
) (
  input logic     CLK,
  input logic     RST,
  uart_rx_if.slave bus
);

  localparam int BIT_W = $clog2(DATA_WIDTH + 1);

  rx_state_t state;
  rx_state_t state_n;

  logic [PRESCALE_W-1:0] edge_cnt;
  logic [PRESCALE_W-1:0] p_lat;
  logic                  pe_lat;
  logic                  pt_lat;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_bad;
  logic                  stop_bad;

  logic sampled_bit;
  logic sample_done;
  logic bit_end;
  logic last_bit;
  logic start_go;

  logic dv;
  logic perr;
  logic serr;

  // >= rather than == so an odd prescale can never strand the counter
  assign bit_end  = (edge_cnt >= p_lat - PRESCALE_W'(1));
  assign last_bit = (bit_cnt == BIT_W'(DATA_WIDTH - 1));
  assign start_go = (state == IDLE) && !bus.RX_IN;

  data_sampling #(
    .PRESCALE_W(PRESCALE_W)
  ) u_smp (
    .CLK        (CLK),
    .RST        (RST),
    .rx_in      (bus.RX_IN),
    .edge_cnt   (edge_cnt),
    .prescale   (p_lat),
    .sampled_bit(sampled_bit),
    .sample_done(sample_done)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (!bus.RX_IN)
          state_n = START;
      end
      START: begin
        if (sample_done && sampled_bit)
          state_n = IDLE;
        else if (bit_end)
          state_n = DATA;
      end
      DATA: begin
        if (bit_end && last_bit)
          state_n = pe_lat ? PARITY : STOP;
      end
      PARITY: begin
        if (bit_end)
          state_n = STOP;
      end
      // leave at the decision point, not the end of the stop bit
      STOP: begin
        if (sample_done || bit_end)
          state_n = OUT;
      end
      OUT: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_comb begin
    dv   = 1'b0;
    perr = 1'b0;
    serr = 1'b0;
    if (state == OUT) begin
      serr = stop_bad;
      perr = par_bad;
      dv   = !stop_bad && !par_bad;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      data_q   <= '0;
      p_lat    <= '0;
      pe_lat   <= 1'b0;
      pt_lat   <= 1'b0;
      par_bad  <= 1'b0;
      stop_bad <= 1'b0;
    end else begin
      // the IDLE cycle that sees the low line is edge 0 of the start bit
      if (state == IDLE)
        edge_cnt <= start_go ? PRESCALE_W'(1) : '0;
      else if (state_n == IDLE || state_n == OUT || bit_end)
        edge_cnt <= '0;
      else
        edge_cnt <= edge_cnt + PRESCALE_W'(1);

      if (start_go) begin
        p_lat    <= bus.prescale;
        pe_lat   <= bus.parity_enable;
        pt_lat   <= bus.parity_type;
        par_bad  <= 1'b0;
        stop_bad <= 1'b0;
        bit_cnt  <= '0;
      end

      if (state == DATA && sample_done)
        shreg <= {sampled_bit, shreg[DATA_WIDTH-1:1]};

      if (state == DATA && bit_end)
        bit_cnt <= bit_cnt + BIT_W'(1);

      if (state == PARITY && sample_done)
        par_bad <= sampled_bit ^ (^shreg) ^ pt_lat;

      if (state == STOP && state_n == OUT) begin
        stop_bad <= !sampled_bit;
        if (sampled_bit && !par_bad)
          data_q <= shreg;
      end
    end
  end

  assign bus.P_DATA       = data_q;
  assign bus.data_valid   = dv;
  assign bus.parity_error = perr;
  assign bus.stop_error   = serr;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are bit-banged on RX_IN and
// expected strobes/words/latency are queued and matched on output.
module tb_uart_rx;
  import parameters_pkg::*;

  typedef struct {
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] pdata;
    int         cyc;
  } exp_t;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  uart_rx_if bus ();

  uart_rx dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  exp_t       q[$];
  int         n_vec = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         dv_cnt = 0;
  logic [7:0] last_good = 8'h00;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  always @(negedge CLK) begin : mon
    exp_t e;
    if (!RST && (bus.data_valid || bus.parity_error || bus.stop_error)) begin
      if (bus.data_valid)
        dv_cnt++;
      if (q.size() == 0) begin
        chk("spurious",
            {29'd0, bus.data_valid, bus.parity_error, bus.stop_error}, 0);
      end else begin
        e = q.pop_front();
        chk("data_valid", {31'd0, bus.data_valid}, {31'd0, e.dv});
        chk("parity_error", {31'd0, bus.parity_error}, {31'd0, e.pe});
        chk("stop_error", {31'd0, bus.stop_error}, {31'd0, e.se});
        chk("P_DATA", {24'd0, bus.P_DATA}, {24'd0, e.pdata});
        chk("latency", cyc, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // entered and left at posedge+1; consecutive calls are back-to-back
  task automatic send(input logic [7:0] d, input int p, input logic pen,
                      input logic pty, input logic bad_par,
                      input logic stop_v, input logic flip);
    exp_t e;
    logic par;
    par = (^d) ^ pty ^ bad_par;
    bus.prescale      = 6'(p);
    bus.parity_enable = pen;
    bus.parity_type   = pty;
    e.se    = !stop_v;
    e.pe    = pen && bad_par;
    e.dv    = !e.se && !e.pe;
    e.pdata = e.dv ? d : last_good;
    e.cyc   = cyc + (9 + int'(pen)) * p + p / 2 + 3;
    if (e.dv)
      last_good = d;
    q.push_back(e);
    for (int b = 0; b < 11; b++) begin
      logic v;
      int   len;
      if (b == 9 && !pen)
        continue;
      if (b == 0)
        v = 1'b0;
      else if (b <= 8)
        v = d[b-1];
      else if (b == 9)
        v = par;
      else
        v = stop_v;
      len = (b == 10 && !stop_v) ? p / 2 + 4 : p;
      if (b == 10) begin
        bus.prescale      = 6'(p);
        bus.parity_enable = pen;
        bus.parity_type   = pty;
      end
      for (int j = 0; j < len; j++) begin
        bus.RX_IN = v ^ (flip && j == p / 2);
        if (b == 0 && j == 1) begin
          bus.prescale      = (p == 16) ? 6'd8 : 6'd16;
          bus.parity_enable = !pen;
          bus.parity_type   = !pty;
        end
        tick();
      end
    end
    bus.RX_IN = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && q.size() != 0; i++)
      tick();
    chk("drain", q.size(), 0);
    q.delete();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0;
    bus.RX_IN         = 1'b1;
    bus.prescale      = 6'd8;
    bus.parity_enable = 1'b0;
    bus.parity_type   = 1'b0;
    RST = 1'b1;
    repeat (3) tick();
    chk("rst_P_DATA", {24'd0, bus.P_DATA}, 0);
    chk("rst_dv", {31'd0, bus.data_valid}, 0);
    chk("rst_pe", {31'd0, bus.parity_error}, 0);
    chk("rst_se", {31'd0, bus.stop_error}, 0);
    chk("rst_state", dut.state, IDLE);
    RST = 1'b0;
    repeat (4) tick();

    send(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drain();
    repeat (5) tick();

    send(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    send(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    drain();
    chk("pdata_hold", {24'd0, bus.P_DATA}, 32'h3C);
    repeat (5) tick();

    send(8'hFF, 32, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();
    repeat (3) tick();
    chk("idle_after_stop_err", dut.state, IDLE);
    chk("pdata_after_stop_err", {24'd0, bus.P_DATA}, 32'h3C);

    bus.prescale      = 6'd16;
    bus.parity_enable = 1'b0;
    bus.RX_IN         = 1'b0;
    repeat (3) tick();
    bus.RX_IN = 1'b1;
    repeat (40) tick();
    chk("idle_after_glitch", dut.state, IDLE);
    send(8'h5A, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drain();
    repeat (5) tick();

    c0 = dv_cnt;
    send(8'h01, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send(8'h80, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    drain();
    chk("dv_twice", dv_cnt - c0, 2);
    repeat (5) tick();

    bus.prescale      = 6'd8;
    bus.parity_enable = 1'b0;
    for (int b = 0; b < 4; b++) begin
      logic [7:0] d77;
      d77 = 8'h77;
      for (int j = 0; j < 8; j++) begin
        bus.RX_IN = (b == 0) ? 1'b0 : d77[b-1];
        tick();
      end
    end
    #3 RST = 1'b1;
    #1;
    chk("midrst_P_DATA", {24'd0, bus.P_DATA}, 0);
    chk("midrst_dv", {31'd0, bus.data_valid}, 0);
    chk("midrst_pe", {31'd0, bus.parity_error}, 0);
    chk("midrst_se", {31'd0, bus.stop_error}, 0);
    chk("midrst_state", dut.state, IDLE);
    bus.RX_IN = 1'b1;
    last_good = 8'h00;
    q.delete();
    repeat (3) tick();
    RST = 1'b0;
    repeat (20) tick();
    send(8'h12, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drain();
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver. It is the downstream partner of the UART transmitter and recovers frames from the serial line RX_IN.
- Frame format: start bit (0), DATA_WIDTH data bits LSB first, an optional parity bit, then one stop bit (1).
- The receiver oversamples each bit by a runtime prescale and takes a 3-sample majority vote at mid-bit.
- It delivers the parallel word with a one-cycle valid strobe and per-frame error flags to the system-side synchroniser/controller.

Parameters:
- DATA_WIDTH, 8 (from parameters_pkg): data bits per frame.
- PRESCALE_W, 6: width of the prescale input and of the edge counter.

Ports:
- CLK  input  1  receiver clock; the oversampling clock, prescale times the bit rate.
- RST  input  1  asynchronous, active-high reset.
- RX_IN  input  1  serial line, idle high; already synchronised to CLK upstream.
- prescale  input  PRESCALE_W  oversampling ratio; legal values are 8, 16, 32.
- parity_enable  input  1  1 = the frame carries a parity bit.
- parity_type  input  1  0 = even parity, 1 = odd parity.
- P_DATA  output  DATA_WIDTH  last correctly received word.
- data_valid  output  1  one-cycle strobe when P_DATA is updated.
- parity_error  output  1  one-cycle strobe on a parity mismatch.
- stop_error  output  1  one-cycle strobe when the stop bit samples 0.

Behaviour:
- Reset, asynchronous on RST=1:
  - state = IDLE.
  - P_DATA = 0, data_valid = 0, parity_error = 0, stop_error = 0.
  - edge_cnt = 0, bit_cnt = 0, shift register = 0.
- Configuration latching: prescale, parity_enable and parity_type are latched on the IDLE→START transition and held for the whole frame. Changing them mid-frame has no effect on that frame.
- Bit timing:
  - edge_cnt counts 0..P-1 within each bit, where P is the latched prescale, then wraps to 0 and bit_cnt advances.
  - Samples are taken at edge_cnt = P/2-1, P/2 and P/2+1.
  - The bit value is the majority of the 3 samples, registered at edge_cnt = P/2+2.
- States:
  - IDLE: edge_cnt held at 0. RX_IN=0 moves to START on the next edge, and that cycle counts as edge_cnt=0 of the start bit.
  - START: at the decision point, if the voted bit is 1 the start is a glitch; return to IDLE with no strobes. Otherwise continue to the end of the bit (edge_cnt=P-1) → DATA.
  - DATA: shift the voted bits in LSB first. After DATA_WIDTH bits, go to PARITY if parity_enable, else to STOP.
  - PARITY: compute the expected parity as XOR of the data bits, inverted when parity_type=1. At the decision point, record a mismatch flag; at the end of the bit → STOP.
  - STOP: at the decision point (edge_cnt = P/2+2) → OUT. The receiver does not wait for the end of the stop bit, which tolerates up to half a bit of clock skew.
  - OUT: single cycle, then → IDLE. Strobe rules in OUT:
    - Stop bit was 0: stop_error=1 and data_valid=0.
    - Else parity mismatch: parity_error=1 and data_valid=0.
    - Else: data_valid=1 and P_DATA is loaded from the shift register.
    - stop_error and parity_error may both be 1 in the same cycle.
    - P_DATA is never updated by an errored frame.
- Latency: data_valid rises exactly 1 cycle after the stop-bit decision point. Measured from the IDLE start edge, that is (1 + DATA_WIDTH + parity_enable)·P + P/2 + 3 cycles.
- Back-to-back frames: a new start bit is accepted starting the cycle after OUT; no idle gap is required.
- Line held low (break): a stop_error frame is produced, then a new frame starts immediately and keeps producing stop_error frames until the line returns high.
- Illegal prescale (not 8/16/32): behaviour unspecified, but there is no lock-up; the FSM still returns to IDLE after a frame.
- RST mid-frame: the frame is abandoned, no strobes are issued, and the state is IDLE.

Decomposition:
- parameters_pkg holds:
  - the rx_state_t enum {IDLE, START, DATA, PARITY, STOP, OUT};
  - PRESCALE_W;
  - the legal prescale constants.
  DATA_WIDTH already lives in parameters_pkg.
- Sub-module data_sampling: contains the edge counter compare and the 3-sample majority voter. It outputs sampled_bit and a one-cycle sample_done pulse, driven by edge_cnt, P and RX_IN.
- The FSM, bit counter, shift register and parity check stay in uart_rx.

Test Plan:
- prescale=8, parity off, send 0xA5 → data_valid pulses once, 1 cycle after the stop decision (cycle 9·8+4+3 = 79 from the start edge); P_DATA=0xA5; no error strobes.
- prescale=16, parity even, send 0x3C with parity bit 0 → P_DATA=0x3C. Resend with parity bit 1 → parity_error=1, data_valid=0, P_DATA stays 0x3C.
- prescale=32, odd parity, send 0xFF with the stop bit driven 0 → stop_error=1, data_valid=0, then the FSM returns to IDLE.
- 3-cycle low glitch on RX_IN with prescale=16 → no strobes, FSM back in IDLE. A following valid frame 0x5A is received correctly.
- Two frames back-to-back (0x01, 0x80) with no idle gap, plus one sample per bit flipped at edge_cnt=P/2 → both words received; data_valid pulses exactly twice.
- RST asserted in the middle of the DATA bits of 0x77 → all outputs 0 immediately. After reset is released, frame 0x12 is received correctly.
